// File: rtl/disp_scan_ctrl.sv
// Six-digit seven-segment scan controller: slot/digit counters, blank-then-ON FSM,
// double-buffered BCD data with frame-aligned transfer and leading-zero suppression.
module disp_scan_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] i_bcd,
   input  logic [5:0]  i_dp,
   input  logic        i_load,
   input  logic        i_lz_en,
   output logic [6:0]  o_seg,
   output logic        o_seg_dp,
   output logic [5:0]  o_seg_enb,
   output logic        o_frame,
   output logic        o_load_ack
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [0:0]    ST_BLANK = 1'b0;
   localparam logic [0:0]    ST_ON    = 1'b1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYC - 1);

   logic          run;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [0:0]    state;
   logic          slot_end;
   logic          frame_end;

   logic [23:0]   pend_bcd;
   logic [5:0]    pend_dp;
   logic          pend_vld;
   logic [23:0]   disp_bcd;
   logic [5:0]    disp_dp;

   logic [3:0]    dig [6];
   logic [5:0]    supp;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1111110;
         4'd1:    seg_decode = 7'b0110000;
         4'd2:    seg_decode = 7'b1101101;
         4'd3:    seg_decode = 7'b1111001;
         4'd4:    seg_decode = 7'b0110011;
         4'd5:    seg_decode = 7'b1011011;
         4'd6:    seg_decode = 7'b1011111;
         4'd7:    seg_decode = 7'b1110000;
         4'd8:    seg_decode = 7'b1111111;
         4'd9:    seg_decode = 7'b1111011;
         default: seg_decode = 7'b0000000;
      endcase
   endfunction

   // run holds the counters on the first edge after reset so cnt = 0 is seen on cycle 0
   assign slot_end  = run && (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 3'd5);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run   <= 1'b0;
         cnt   <= '0;
         idx   <= 3'd0;
         state <= ST_BLANK;
      end else begin
         run <= 1'b1;
         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         end else if (run) begin
            cnt <= cnt + CW'(1);
         end
         case (state)
            ST_BLANK: if (run && cnt == CNT_ON) state <= ST_ON;
            ST_ON:    if (slot_end) state <= ST_BLANK;
            default:  state <= ST_BLANK;
         endcase
      end
   end

   // A strobe on the boundary edge still lets the older pending data transfer first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_bcd <= '0;
         pend_dp  <= '0;
         pend_vld <= 1'b0;
         disp_bcd <= '0;
         disp_dp  <= '0;
      end else begin
         if (frame_end && pend_vld) begin
            disp_bcd <= pend_bcd;
            disp_dp  <= pend_dp;
         end
         if (i_load) begin
            pend_bcd <= i_bcd;
            pend_dp  <= i_dp;
            pend_vld <= 1'b1;
         end else if (frame_end) begin
            pend_vld <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < 6; g++) begin : g_dig
      assign dig[g] = disp_bcd[4*g +: 4];
   end

   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      supp     = '0;
      for (int k = 5; k >= 1; k--) begin
         zero_run = zero_run && (dig[k] == 4'd0);
         supp[k]  = zero_run;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_seg      <= 7'd0;
         o_seg_dp   <= 1'b0;
         o_seg_enb  <= 6'b111111;
         o_frame    <= 1'b0;
         o_load_ack <= 1'b0;
      end else begin
         o_frame    <= frame_end;
         o_load_ack <= frame_end && pend_vld;
         if (state == ST_ON) begin
            o_seg_enb <= ~(6'b000001 << idx);
            o_seg     <= (i_lz_en && supp[idx]) ? 7'd0 : seg_decode(dig[idx]);
            o_seg_dp  <= disp_dp[idx];
         end else begin
            o_seg_enb <= 6'b111111;
            o_seg     <= 7'd0;
            o_seg_dp  <= 1'b0;
         end
      end
   end

endmodule
